// File: rtl/instruction_fetch.sv
// Instruction fetch stage: a PC register that addresses a combinational
// instruction memory and an IF/ID register, plus a sticky fetch-fault flag.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] imem_address,
  input  logic [31:0] imem_data,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instruction,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  // Handshake: ifid_valid marks a real instruction; stall is the downstream
  // not-ready signal, and while it is high (with no redirect) IF/ID is frozen.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES) - 64'd4;

  logic [63:0] pc;
  logic [63:0] pc_next;
  logic [63:0] aligned_target;
  logic        in_range;
  logic        fetch_slot;
  logic        capture;
  logic        range_fault;
  logic        misaligned;
  logic        hold_ifid;

  assign imem_address = pc;

  always_comb begin
    aligned_target = {branch_target[63:2], 2'b00};
    in_range       = (pc <= LAST_ADDR);
    fetch_slot     = !fetch_fault && !branch_taken && !flush && !stall;
    capture        = fetch_slot && in_range;
    range_fault    = fetch_slot && !in_range;
    misaligned     = !fetch_fault && branch_taken && (branch_target[1:0] != 2'b00);
    hold_ifid      = stall && !branch_taken && !flush && !fetch_fault;
    // An out-of-range fetch parks the PC on the offending address.
    pc_next = pc;
    if (!fetch_fault) begin
      if (branch_taken) begin
        pc_next = aligned_target;
      end else if (!stall && !range_fault) begin
        pc_next = pc + 64'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc               <= RESET_PC;
      ifid_pc          <= 64'd0;
      ifid_instruction <= 32'd0;
      ifid_valid       <= 1'b0;
      fetch_fault      <= 1'b0;
      fetch_count      <= 32'd0;
    end else begin
      pc <= pc_next;
      if (capture) begin
        ifid_pc          <= pc;
        ifid_instruction <= imem_data;
        ifid_valid       <= 1'b1;
        fetch_count      <= fetch_count + 32'd1;
      end else if (!hold_ifid) begin
        ifid_valid <= 1'b0;
      end
      if (range_fault || misaligned) begin
        fetch_fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, all
// checked against a transaction-level model through an expected-state queue.
module tb_instruction_fetch;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] ifid_pc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic [31:0] count;
  } snap_t;

  localparam int SNAP_W = $bits(snap_t);
  localparam int MEMB   = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'd0;
  logic [63:0] imem_address;
  logic [31:0] imem_data;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instruction;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [7:0]        mem [MEMB];
  logic [SNAP_W-1:0] exp_q[$];
  snap_t             m;
  int                vectors = 0;
  int                miscompares = 0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(64'h0), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_address(imem_address), .imem_data(imem_data),
    .ifid_pc(ifid_pc), .ifid_instruction(ifid_instruction),
    .ifid_valid(ifid_valid), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  // Little-endian memory model answering combinationally.
  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_address <= 64'd252) begin
      imem_data = {mem[int'(imem_address[7:0]) + 3], mem[int'(imem_address[7:0]) + 2],
                   mem[int'(imem_address[7:0]) + 1], mem[int'(imem_address[7:0])]};
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] word_at(input logic [63:0] a);
    int b;
    b = int'(a[7:0]);
    return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
  endfunction

  task automatic model_step(input logic r, input logic s, input logic f,
                            input logic b, input logic [63:0] t);
    if (!r) begin
      m = '0;
    end else if (m.fault) begin
      m.valid = 1'b0;
    end else if (b) begin
      if (t % 4 != 0) m.fault = 1'b1;
      m.pc    = t - (t % 4);
      m.valid = 1'b0;
    end else if (f) begin
      m.valid = 1'b0;
      if (!s) m.pc = m.pc + 64'd4;
    end else if (s) begin
      // nothing moves
    end else if (m.pc > MEMB - 4) begin
      m.fault = 1'b1;
      m.valid = 1'b0;
    end else begin
      m.ifid_pc = m.pc;
      m.instr   = word_at(m.pc);
      m.valid   = 1'b1;
      m.count   = m.count + 32'd1;
      m.pc      = m.pc + 64'd4;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic r, input logic s, input logic f,
                             input logic b, input logic [63:0] t);
    rst = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    model_step(r, s, f, b, t);
    exp_q.push_back(SNAP_W'(m));
    @(posedge clk);
    #1;
  endtask

  task automatic run_normal(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic do_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    snap_t e;
    snap_t g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = snap_t'(exp_q.pop_front());
        g.pc = imem_address; g.ifid_pc = ifid_pc; g.instr = ifid_instruction;
        g.valid = ifid_valid; g.fault = fetch_fault; g.count = fetch_count;
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL state @%0t: got pc=%0h ifid_pc=%0h instr=%0h v=%0b f=%0b cnt=%0d expected pc=%0h ifid_pc=%0h instr=%0h v=%0b f=%0b cnt=%0d",
                   $time, g.pc, g.ifid_pc, g.instr, g.valid, g.fault, g.count,
                   e.pc, e.ifid_pc, e.instr, e.valid, e.fault, e.count);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] W0 = 32'h8B1F03E5;
  localparam logic [31:0] W1 = 32'hF84000A4;
  localparam logic [31:0] W2 = 32'h8B040086;
  localparam logic [31:0] W3 = 32'hF80010A6;

  initial begin
    logic [31:0] words [4];
    logic [63:0] tgt;
    logic        r, s, f, b;
    int          drain;
    words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
    for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++) mem[w * 4 + k] = words[w][k * 8 +: 8];
    m = '0;

    // Reset values
    do_reset();
    do_reset();
    check("reset_pc", imem_address, 64'd0);
    check("reset_ifid_pc", ifid_pc, 64'd0);
    check("reset_instr", {32'd0, ifid_instruction}, 64'd0);
    check("reset_valid_fault", {62'd0, ifid_valid, fetch_fault}, 64'd0);
    check("reset_count", {32'd0, fetch_count}, 64'd0);

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      run_normal(1);
      check("seq_ifid_pc", ifid_pc, 64'(i * 4));
      check("seq_instr", {32'd0, ifid_instruction}, {32'd0, words[i]});
      check("seq_valid", {63'd0, ifid_valid}, 64'd1);
    end
    check("seq_count", {32'd0, fetch_count}, 64'd4);

    // Stall at pc=8, then branch with stall
    do_reset();
    run_normal(2);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
      check("stall_pc", imem_address, 64'd8);
      check("stall_ifid_pc", ifid_pc, 64'd4);
      check("stall_instr", {32'd0, ifid_instruction}, {32'd0, W1});
      check("stall_count", {32'd0, fetch_count}, 64'd2);
    end
    run_normal(1);
    check("post_stall_instr", {32'd0, ifid_instruction}, {32'd0, W2});
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, 64'd4);
    check("brstall_pc", imem_address, 64'd4);
    check("brstall_valid", {63'd0, ifid_valid}, 64'd0);
    run_normal(1);
    check("brstall_ifid_pc", ifid_pc, 64'd4);
    check("brstall_instr", {32'd0, ifid_instruction}, {32'd0, W1});

    // Range fault
    do_reset();
    run_normal(64);
    check("range_count", {32'd0, fetch_count}, 64'd64);
    check("range_last_pc", ifid_pc, 64'd252);
    run_normal(1);
    check("range_fault", {63'd0, fetch_fault}, 64'd1);
    check("range_valid", {63'd0, ifid_valid}, 64'd0);
    check("range_pc", imem_address, 64'd256);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'd8);
    check("range_branch_ignored", imem_address, 64'd256);

    // Misaligned branch
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 64'h6);
    check("mis_fault", {63'd0, fetch_fault}, 64'd1);
    check("mis_pc", imem_address, 64'h4);
    run_normal(2);
    check("mis_hold_pc", imem_address, 64'h4);

    // Reset mid-stall
    do_reset();
    run_normal(2);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    check("rst_mid_pc", imem_address, 64'd0);
    check("rst_mid_ifid", ifid_pc | {32'd0, ifid_instruction}, 64'd0);
    check("rst_mid_flags", {62'd0, ifid_valid, fetch_fault}, 64'd0);
    check("rst_mid_count", {32'd0, fetch_count}, 64'd0);
    run_normal(1);
    check("first_capture", {63'd0, ifid_valid}, 64'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 15))
        0:       tgt = {$urandom, $urandom};
        1, 2:    tgt = 64'($urandom_range(0, 255));
        default: tgt = 64'($urandom_range(0, 63)) * 64'd4;
      endcase
      drive_cycle(r, s, f, b, tgt);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 8) begin
      @(negedge clk);
      #1;
      drain++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
